// File: rtl/door_pkg.sv
// Shared definitions for the door sprite animator.
//   door_state_t : door FSM states (open, closing, closed, opening)
//   NUM_FRAMES   : frames in the open->closed sequence, index 0 is fully open
//   FRAME_HOLD   : vblank ticks each frame is held while the door moves
//   FRAME_WORDS  : ROM words per stacked frame (105x66)
//   V_ACTIVE     : first non-visible line; the vblank tick fires there
//   frame_base() : frame index -> word offset into the stacked-frame ROM
package door_pkg;

   localparam int unsigned NUM_FRAMES  = 6;
   localparam int unsigned FRAME_HOLD  = 4;
   localparam int unsigned FRAME_WORDS = 6930;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned FRAME_IDX_W = $clog2(NUM_FRAMES);
   localparam int unsigned ROM_BASE_W  = 16;

   typedef enum logic [1:0] {
      StOpen,
      StClosing,
      StClosed,
      StOpening
   } door_state_t;

   // 16-bit unsigned product; the largest offset (5 * 6930 = 34650) fits.
   function automatic logic [ROM_BASE_W-1:0] frame_base(input logic [FRAME_IDX_W-1:0] idx);
      return ROM_BASE_W'(idx) * ROM_BASE_W'(FRAME_WORDS);
   endfunction

endpackage

// File: rtl/door_anim_ctrl_if.sv
// Signal bundle between the raster/game side and the door animator.
//   draw_x, draw_y : current pixel column/row from the VGA counter
//   toggle_req     : button level; a rising edge requests a toggle
//   power_ok       : 0 forces the door open and ignores toggles
//   frame_idx      : current animation frame
//   rom_base       : frame_idx * FRAME_WORDS, added to the renderer address
//   door_closed    : high only while the door is fully closed
//   busy           : high while the door is closing or opening
// master drives the raster/button side, slave is the animator.
interface door_anim_ctrl_if;
   import door_pkg::*;

   logic [9:0]             draw_x;
   logic [9:0]             draw_y;
   logic                   toggle_req;
   logic                   power_ok;
   logic [FRAME_IDX_W-1:0] frame_idx;
   logic [ROM_BASE_W-1:0]  rom_base;
   logic                   door_closed;
   logic                   busy;

   modport master (
      output draw_x,
      output draw_y,
      output toggle_req,
      output power_ok,
      input  frame_idx,
      input  rom_base,
      input  door_closed,
      input  busy
   );

   modport slave (
      input  draw_x,
      input  draw_y,
      input  toggle_req,
      input  power_ok,
      output frame_idx,
      output rom_base,
      output door_closed,
      output busy
   );

endinterface

// File: rtl/vblank_tick.sv
// Decodes the raster position into a once-per-frame tick at the start of vblank.
//   i_draw_x : current pixel column
//   i_draw_y : current pixel row
//   o_tick   : high for the single pixel clock where column 0 of line VActive is drawn
// The raster counter sits on (0, VActive) for exactly one cycle, so a plain
// decode already yields a one-cycle pulse.
module vblank_tick #(
   parameter int unsigned VActive = 480
) (
   input  logic [9:0] i_draw_x,
   input  logic [9:0] i_draw_y,
   output logic       o_tick
);

   assign o_tick = (i_draw_x == 10'd0) && (i_draw_y == 10'(VActive));

endmodule

// File: rtl/door_anim_ctrl.sv
// Door sprite sequencer: runs the open/closing/closed/opening state machine
// and steps the animation frame only at vblank so a visible frame never tears.
//   i_vga_clk : pixel clock, all logic on its rising edge
//   i_reset   : synchronous, active-high
//   io_door   : slave side of door_anim_ctrl_if (raster position, toggle
//               button, power status in; frame index, ROM base, closed and
//               busy flags out)
// All outputs are registered; door_closed/busy are decoded from the next
// state so they change in the same cycle as the state itself.
module door_anim_ctrl
   import door_pkg::*;
#(
   parameter int unsigned FrameHold = FRAME_HOLD
) (
   input logic             i_vga_clk,
   input logic             i_reset,
   door_anim_ctrl_if.slave io_door
);

   localparam int unsigned             HoldW    = (FrameHold > 1) ? $clog2(FrameHold) : 1;
   localparam logic [HoldW-1:0]        HoldMax  = HoldW'(FrameHold - 1);
   localparam logic [FRAME_IDX_W-1:0]  IdxLast  = FRAME_IDX_W'(NUM_FRAMES - 1);
   localparam logic [FRAME_IDX_W-1:0]  IdxFirst = '0;

   door_state_t            r_state;
   logic [HoldW-1:0]       r_hold_cnt;
   logic                   r_pending;
   logic                   r_toggle_q;
   logic [FRAME_IDX_W-1:0] r_frame_idx;
   logic [ROM_BASE_W-1:0]  r_rom_base;
   logic                   r_door_closed;
   logic                   r_busy;

   logic                   w_tick;
   logic                   w_rise;
   logic                   w_consume;
   logic                   w_hold_done;
   logic [FRAME_IDX_W-1:0] w_idx_inc;
   logic [FRAME_IDX_W-1:0] w_idx_dec;

   vblank_tick #(
      .VActive (V_ACTIVE)
   ) u_vblank_tick (
      .i_draw_x (io_door.draw_x),
      .i_draw_y (io_door.draw_y),
      .o_tick   (w_tick)
   );

   assign w_rise      = io_door.toggle_req & ~r_toggle_q;
   assign w_hold_done = (r_hold_cnt == HoldMax);
   assign w_idx_inc   = r_frame_idx + 1'b1;
   assign w_idx_dec   = r_frame_idx - 1'b1;

   // A pending request is used up only by a tick that acts on it.
   always_comb begin
      w_consume = 1'b0;
      if (w_tick) begin
         case (r_state)
            StOpen, StOpening:  w_consume = r_pending & io_door.power_ok;
            StClosing, StClosed: w_consume = r_pending | ~io_door.power_ok;
            default:            w_consume = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_vga_clk) begin
      if (i_reset) begin
         r_state       <= StOpen;
         r_hold_cnt    <= '0;
         r_pending     <= 1'b0;
         r_toggle_q    <= 1'b0;
         r_frame_idx   <= '0;
         r_rom_base    <= '0;
         r_door_closed <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_toggle_q <= io_door.toggle_req;

         // A fresh edge landing on the consuming tick survives as a new request.
         if (!io_door.power_ok) begin
            r_pending <= 1'b0;
         end else if (w_rise) begin
            r_pending <= 1'b1;
         end else if (w_consume) begin
            r_pending <= 1'b0;
         end

         if (w_tick) begin
            case (r_state)
               StOpen: begin
                  if (r_pending && io_door.power_ok) begin
                     r_state    <= StClosing;
                     r_hold_cnt <= '0;
                     r_busy     <= 1'b1;
                  end
               end

               StClosing: begin
                  if (!io_door.power_ok || r_pending) begin
                     // Reverse in place: the current frame is kept.
                     r_state    <= StOpening;
                     r_hold_cnt <= '0;
                  end else if (w_hold_done) begin
                     r_hold_cnt <= '0;
                     if (r_frame_idx != IdxLast) begin
                        r_frame_idx <= w_idx_inc;
                        r_rom_base  <= frame_base(w_idx_inc);
                     end
                     if ((r_frame_idx == IdxLast) || (w_idx_inc == IdxLast)) begin
                        r_state       <= StClosed;
                        r_busy        <= 1'b0;
                        r_door_closed <= 1'b1;
                     end
                  end else begin
                     r_hold_cnt <= r_hold_cnt + 1'b1;
                  end
               end

               StClosed: begin
                  if (!io_door.power_ok || r_pending) begin
                     r_state       <= StOpening;
                     r_hold_cnt    <= '0;
                     r_busy        <= 1'b1;
                     r_door_closed <= 1'b0;
                  end
               end

               StOpening: begin
                  if (r_pending && io_door.power_ok) begin
                     r_state    <= StClosing;
                     r_hold_cnt <= '0;
                  end else if (w_hold_done) begin
                     r_hold_cnt <= '0;
                     if (r_frame_idx != IdxFirst) begin
                        r_frame_idx <= w_idx_dec;
                        r_rom_base  <= frame_base(w_idx_dec);
                     end
                     if ((r_frame_idx == IdxFirst) || (w_idx_dec == IdxFirst)) begin
                        r_state <= StOpen;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_hold_cnt <= r_hold_cnt + 1'b1;
                  end
               end

               default: begin
                  r_state       <= StOpen;
                  r_hold_cnt    <= '0;
                  r_frame_idx   <= '0;
                  r_rom_base    <= '0;
                  r_door_closed <= 1'b0;
                  r_busy        <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io_door.frame_idx   = r_frame_idx;
   assign io_door.rom_base    = r_rom_base;
   assign io_door.door_closed = r_door_closed;
   assign io_door.busy        = r_busy;

endmodule

// File: tb/tb_door_anim_ctrl.sv
// Directed bench for door_anim_ctrl with a 2-tick frame hold. The raster is
// driven as short windows of an 800x525 scan: mid-frame positions for button
// activity and the (799,479) -> (0,480) -> (1,480) step for each vblank tick.
module tb_door_anim_ctrl;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   logic [15:0] base_tbl [0:5] = '{16'd0, 16'd6930, 16'd13860, 16'd20790, 16'd27720, 16'd34650};
   logic [20:0] w_obs;

   door_anim_ctrl_if u_if ();

   door_anim_ctrl #(
      .FrameHold (2)
   ) u_dut (
      .i_vga_clk (clk),
      .i_reset   (rst),
      .io_door   (u_if)
   );

   assign w_obs = {u_if.frame_idx, u_if.rom_base, u_if.door_closed, u_if.busy};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic set_pos(input logic [9:0] x, input logic [9:0] y);
      @(posedge clk);
      #1;
      u_if.draw_x = x;
      u_if.draw_y = y;
   endtask

   // Presents one vblank tick, then waits to the negedge after it is consumed.
   task automatic do_tick();
      set_pos(10'd799, 10'd479);
      set_pos(10'd0, 10'd480);
      set_pos(10'd1, 10'd480);
      @(negedge clk);
   endtask

   task automatic pulse_toggle();
      set_pos(10'd100, 10'd200);
      u_if.toggle_req = 1'b1;
      set_pos(10'd101, 10'd200);
      u_if.toggle_req = 1'b0;
      set_pos(10'd102, 10'd200);
   endtask

   task automatic test_reset();
      logic [20:0] want;
      rst = 1'b1;
      repeat (2) set_pos(10'd400, 10'd100);
      rst = 1'b0;
      @(negedge clk);
      want = {3'd0, 16'd0, 1'b0, 1'b0};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL reset: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
   endtask

   // rom_base tracks frame_idx; frame_idx moves only after a tick or reset.
   task automatic test_invariants();
      logic [2:0]  prev_idx;
      logic        prev_tick;
      logic        prev_rst;
      logic [31:0] want_base;
      prev_idx  = u_if.frame_idx;
      prev_tick = 1'b0;
      prev_rst  = rst;
      forever begin
         @(negedge clk);
         want_base = {29'd0, u_if.frame_idx} * 32'd6930;
         n_vec++;
         if ({16'd0, u_if.rom_base} !== want_base) begin
            n_err++;
            $display("FAIL base_invariant: got rom_base %0d want %0d", u_if.rom_base, want_base);
         end
         n_vec++;
         if ((u_if.frame_idx !== prev_idx) && !prev_tick && !prev_rst) begin
            n_err++;
            $display("FAIL idx_off_tick: got frame_idx %0d want %0d", u_if.frame_idx, prev_idx);
         end
         prev_idx  = u_if.frame_idx;
         prev_tick = (u_if.draw_x == 10'd0) && (u_if.draw_y == 10'd480);
         prev_rst  = rst;
      end
   endtask

   task automatic test_close();
      logic [20:0] want;
      pulse_toggle();
      @(negedge clk);
      want = {3'd0, 16'd0, 1'b0, 1'b0};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL close_wait: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      do_tick();
      want = {3'd0, 16'd0, 1'b0, 1'b1};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL close_start: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      for (int k = 1; k <= 5; k++) begin
         do_tick();
         want = {3'(k - 1), base_tbl[k - 1], 1'b0, 1'b1};
         n_vec++;
         if (w_obs !== want) begin
            n_err++;
            $display("FAIL close_hold k=%0d: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", k,
                     w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                     want[20:18], want[17:2], want[1], want[0]);
         end
         do_tick();
         want = {3'(k), base_tbl[k], (k == 5), (k != 5)};
         n_vec++;
         if (w_obs !== want) begin
            n_err++;
            $display("FAIL close_step k=%0d: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", k,
                     w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                     want[20:18], want[17:2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_open();
      logic [20:0] want;
      pulse_toggle();
      do_tick();
      want = {3'd5, 16'd34650, 1'b0, 1'b1};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL open_start: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      for (int k = 4; k >= 0; k--) begin
         do_tick();
         want = {3'(k + 1), base_tbl[k + 1], 1'b0, 1'b1};
         n_vec++;
         if (w_obs !== want) begin
            n_err++;
            $display("FAIL open_hold k=%0d: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", k,
                     w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                     want[20:18], want[17:2], want[1], want[0]);
         end
         do_tick();
         want = {3'(k), base_tbl[k], 1'b0, (k != 0)};
         n_vec++;
         if (w_obs !== want) begin
            n_err++;
            $display("FAIL open_step k=%0d: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", k,
                     w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                     want[20:18], want[17:2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_reverse();
      logic [20:0] want;
      pulse_toggle();
      repeat (7) do_tick();
      want = {3'd3, 16'd20790, 1'b0, 1'b1};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL rev_at3: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      pulse_toggle();
      do_tick();
      repeat (1) do_tick();
      // One hold tick after the reversal the frame must still be 3.
      want = {3'd3, 16'd20790, 1'b0, 1'b1};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL rev_hold: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      for (int k = 2; k >= 0; k--) begin
         do_tick();
         want = {3'(k), base_tbl[k], 1'b0, (k != 0)};
         n_vec++;
         if (w_obs !== want) begin
            n_err++;
            $display("FAIL rev_step k=%0d: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", k,
                     w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                     want[20:18], want[17:2], want[1], want[0]);
         end
         if (k != 0) do_tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [20:0] want;
      pulse_toggle();
      pulse_toggle();
      repeat (3) do_tick();
      want = {3'd1, 16'd6930, 1'b0, 1'b1};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL absorb: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      pulse_toggle();
      repeat (3) do_tick();
      want = {3'd0, 16'd0, 1'b0, 1'b0};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL absorb_back: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
   endtask

   task automatic test_power();
      logic [20:0] want;
      pulse_toggle();
      repeat (11) do_tick();
      set_pos(10'd50, 10'd300);
      u_if.power_ok = 1'b0;
      pulse_toggle();
      @(negedge clk);
      want = {3'd5, 16'd34650, 1'b1, 1'b0};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL pwr_wait: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      do_tick();
      want = {3'd5, 16'd34650, 1'b0, 1'b1};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL pwr_open: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      for (int k = 4; k >= 0; k--) begin
         pulse_toggle();
         do_tick();
         do_tick();
         want = {3'(k), base_tbl[k], 1'b0, (k != 0)};
         n_vec++;
         if (w_obs !== want) begin
            n_err++;
            $display("FAIL pwr_step k=%0d: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", k,
                     w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                     want[20:18], want[17:2], want[1], want[0]);
         end
      end
      pulse_toggle();
      repeat (3) do_tick();
      want = {3'd0, 16'd0, 1'b0, 1'b0};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL pwr_stay: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      set_pos(10'd60, 10'd300);
      u_if.power_ok = 1'b1;
      do_tick();
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL pwr_restore: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [20:0] want;
      pulse_toggle();
      repeat (9) do_tick();
      want = {3'd4, 16'd27720, 1'b0, 1'b1};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL rst_at4: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      set_pos(10'd300, 10'd100);
      rst = 1'b1;
      set_pos(10'd301, 10'd100);
      rst = 1'b0;
      @(negedge clk);
      want = {3'd0, 16'd0, 1'b0, 1'b0};
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL rst_mid: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
      do_tick();
      n_vec++;
      if (w_obs !== want) begin
         n_err++;
         $display("FAIL rst_idle: got idx/base/closed/busy %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                  w_obs[20:18], w_obs[17:2], w_obs[1], w_obs[0],
                  want[20:18], want[17:2], want[1], want[0]);
      end
   endtask

   initial begin
      n_vec           = 0;
      n_err           = 0;
      rst             = 1'b1;
      u_if.draw_x     = 10'd400;
      u_if.draw_y     = 10'd100;
      u_if.toggle_req = 1'b0;
      u_if.power_ok   = 1'b1;

      test_reset();
      fork
         test_invariants();
      join_none
      test_close();
      test_open();
      test_reverse();
      test_back_to_back();
      test_power();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
